// File: rtl/sram_pkg.sv
// Shared types and default timing for the clocked async-SRAM device model.
package sram_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned ADDR_W_DEF     = 18;
  localparam int unsigned DEPTH_LOG2_DEF = 10;

  localparam int unsigned T_AA_CYC_DEF  = 2;
  localparam int unsigned T_SA_CYC_DEF  = 1;
  localparam int unsigned T_PWE_CYC_DEF = 2;
  localparam int unsigned T_H_CYC_DEF   = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE_PULSE,
    WRITE_HOLD
  } state_e;

  // Width for the timing counters: enough to reach the largest limit, plus headroom to saturate.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $unsigned($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Word storage: one synchronous write port, two asynchronous read ports (bus and backdoor).
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_a_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  input  logic [DEPTH_LOG2-1:0] raddr_b_i,
  output logic [DATA_W-1:0]     rdata_b_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/sram_responder.sv
// Device end of the async SRAM bus: registered input sampling, access-delay reads,
// WE-rising-edge writes and sticky timing-violation flags.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned T_AA_CYC   = T_AA_CYC_DEF,
  parameter int unsigned T_SA_CYC   = T_SA_CYC_DEF,
  parameter int unsigned T_PWE_CYC  = T_PWE_CYC_DEF,
  parameter int unsigned T_H_CYC    = T_H_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     RamAddr,
  inout  wire  [DATA_W-1:0]     RamData,
  input  logic                  RamOE,
  input  logic                  RamWE,
  input  logic                  RamEN,
  output logic                  err_setup,
  output logic                  err_pwe,
  output logic                  err_addr,
  output logic                  err_hold,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int unsigned CW        = cnt_w(T_AA_CYC, T_SA_CYC, T_PWE_CYC, T_H_CYC);
  localparam int unsigned HOLD_LAST = (T_H_CYC > 0) ? T_H_CYC - 1 : 0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  state_e                state_q;
  logic [ADDR_W-1:0]     s_addr_q;
  logic                  s_oe_q, s_we_q, s_en_q;
  logic [DATA_W-1:0]     s_data_q;
  logic                  chg_q, chg_d;
  logic [CW-1:0]         stable_q, stable_d;
  logic [CW-1:0]         acc_q, pw_q, h_q;
  logic [DEPTH_LOG2-1:0] waddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  abort_q;
  logic                  err_setup_q, err_pwe_q, err_addr_q, err_hold_q;
  logic [15:0]           wr_cnt_q, rd_cnt_q;

  logic                  hold_done, eval_idle, start_wr, start_rd, wr_end, commit, bus_drive;
  logic [DATA_W-1:0]     bus_rdata;

  always_comb begin
    chg_d     = (RamAddr != s_addr_q);
    stable_d  = chg_d ? '0 : sat_inc(stable_q);
    hold_done = (state_q == WRITE_HOLD) && (h_q >= CW'(HOLD_LAST));
    eval_idle = (state_q == IDLE) || hold_done;
    // Write wins over OE whenever the chip is enabled, including from the read states.
    start_wr  = !s_en_q && !s_we_q &&
                (eval_idle || (state_q == READ_WAIT) || (state_q == READ_DRIVE));
    start_rd  = eval_idle && !s_en_q && s_we_q && !s_oe_q;
    wr_end    = (state_q == WRITE_PULSE) && (s_we_q || s_en_q);
    commit    = wr_end && !abort_q && (pw_q >= CW'(T_PWE_CYC));
    bus_drive = (state_q == READ_DRIVE) && !s_en_q && !s_oe_q && s_we_q && !chg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_addr_q <= '0;
      s_oe_q   <= 1'b1;
      s_we_q   <= 1'b1;
      s_en_q   <= 1'b1;
      s_data_q <= '0;
      chg_q    <= 1'b0;
      stable_q <= '0;
    end else begin
      s_addr_q <= RamAddr;
      s_oe_q   <= RamOE;
      s_we_q   <= RamWE;
      s_en_q   <= RamEN;
      s_data_q <= RamData;
      chg_q    <= chg_d;
      stable_q <= stable_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pw_q        <= '0;
      h_q         <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      abort_q     <= 1'b0;
      err_setup_q <= 1'b0;
      err_pwe_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      err_hold_q  <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      if ((state_q == WRITE_HOLD) && chg_q) err_hold_q <= 1'b1;

      if (start_wr) begin
        state_q <= WRITE_PULSE;
        pw_q    <= CW'(1);
        waddr_q <= s_addr_q[DEPTH_LOG2-1:0];
        wdata_q <= s_data_q;
        abort_q <= 1'b0;
        if (stable_q < CW'(T_SA_CYC)) err_setup_q <= 1'b1;
      end else if (start_rd) begin
        state_q <= READ_WAIT;
        acc_q   <= CW'(1);
      end else begin
        case (state_q)
          READ_WAIT: begin
            if (s_en_q || s_oe_q) begin
              state_q <= IDLE;
            end else if (chg_q) begin
              acc_q <= CW'(1);
            end else if (acc_q >= CW'(T_AA_CYC)) begin
              state_q  <= READ_DRIVE;
              rd_cnt_q <= rd_cnt_q + 16'd1;
            end else begin
              acc_q <= sat_inc(acc_q);
            end
          end
          READ_DRIVE: begin
            if (s_en_q || s_oe_q) begin
              state_q <= IDLE;
            end else if (chg_q) begin
              state_q <= READ_WAIT;
              acc_q   <= CW'(1);
            end
          end
          WRITE_PULSE: begin
            if (wr_end) begin
              state_q <= WRITE_HOLD;
              h_q     <= '0;
              if (commit) wr_cnt_q <= wr_cnt_q + 16'd1;
              if (pw_q < CW'(T_PWE_CYC)) err_pwe_q <= 1'b1;
              // An address move on the rising-edge cycle is already inside the hold window.
              if (chg_q) err_hold_q <= 1'b1;
            end else begin
              pw_q    <= sat_inc(pw_q);
              wdata_q <= s_data_q;
              if (chg_q) begin
                err_addr_q <= 1'b1;
                abort_q    <= 1'b1;
              end
            end
          end
          WRITE_HOLD: begin
            if (hold_done) state_q <= IDLE;
            else           h_q     <= sat_inc(h_q);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i     (clk),
    .we_i      (commit),
    .waddr_i   (waddr_q),
    .wdata_i   (wdata_q),
    .raddr_a_i (s_addr_q[DEPTH_LOG2-1:0]),
    .rdata_a_o (bus_rdata),
    .raddr_b_i (dbg_addr),
    .rdata_b_o (dbg_data)
  );

  assign RamData   = bus_drive ? bus_rdata : {DATA_W{1'bz}};
  assign err_setup = err_setup_q;
  assign err_pwe   = err_pwe_q;
  assign err_addr  = err_addr_q;
  assign err_hold  = err_hold_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: reads are scored by a bus monitor, flags/counters/memory checked directly.
`timescale 1ns/1ps
module tb_sram_responder;
  import sram_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 18;
  localparam int unsigned DL = 10;
  localparam int unsigned TAA = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          oe = 1'b1, we = 1'b1, en = 1'b1;
  logic [DW-1:0] dat = '0;
  logic          dat_en = 1'b0;
  logic [DL-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          err_setup, err_pwe, err_addr, err_hold;
  logic [15:0]   wr_count, rd_count;
  tri1  [DW-1:0] RamData;

  assign RamData = dat_en ? dat : {DW{1'bz}};

  sram_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL),
    .T_AA_CYC(TAA), .T_SA_CYC(1), .T_PWE_CYC(2), .T_H_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .RamAddr(addr), .RamData(RamData),
    .RamOE(oe), .RamWE(we), .RamEN(en),
    .err_setup(err_setup), .err_pwe(err_pwe), .err_addr(err_addr), .err_hold(err_hold),
    .wr_count(wr_count), .rd_count(rd_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  logic        x_setup = 0, x_pwe = 0, x_addr = 0, x_hold = 0;
  logic [15:0] x_wr = 0, x_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".err_setup"}, 32'(err_setup), 32'(x_setup));
    chk({tag, ".err_pwe"},   32'(err_pwe),   32'(x_pwe));
    chk({tag, ".err_addr"},  32'(err_addr),  32'(x_addr));
    chk({tag, ".err_hold"},  32'(err_hold),  32'(x_hold));
    chk({tag, ".wr_count"},  32'(wr_count),  32'(x_wr));
    chk({tag, ".rd_count"},  32'(rd_count),  32'(x_rd));
  endtask

  task automatic mem_chk(input string name, input logic [DL-1:0] a, input logic [DW-1:0] d);
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_data), 32'(d));
    @(negedge clk);
  endtask

  // Write cycle: pre = cycles of address setup before WE falls, low = WE-low cycles.
  task automatic wr_raw(input logic [AW-1:0] a, input logic [DW-1:0] d, input int pre,
                        input int low, input bit oe_low);
    addr = a; en = 1'b0; oe = 1'b1; we = 1'b1;
    repeat (pre) @(negedge clk);
    we = 1'b0; oe = !oe_low; dat = d; dat_en = 1'b1;
    repeat (low) @(negedge clk);
    we = 1'b1; oe = 1'b1;
    @(negedge clk);
    dat_en = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    addr = a; en = 1'b0; oe = 1'b0; we = 1'b1;
    e.data = d;
    e.cyc  = cyc + int'(TAA) + 2;
    sb.push_back(e);
    repeat (TAA + 5) @(negedge clk);
    oe = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    chk({name, ".consumed"}, 32'(sb.size()), 32'd0);
    sb.delete();
    x_rd++;
  endtask

  // Monitor: every start of a DUT-driven bus interval must match the next queued read.
  initial begin : monitor
    bit   prev;
    bit   drv;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      drv = !dat_en && (RamData !== {DW{1'b1}});
      if (drv && !prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_drive: got %h at cycle %0d, expected released bus", RamData, cyc);
        end else begin
          e = sb.pop_front();
          chk("rd_data", 32'(RamData), 32'(e.data));
          chk("rd_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      prev = drv;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.bus", 32'(RamData), 32'h0000FFFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    wr_raw(18'h00012, 16'hBEEF, 2, 3, 1'b0);
    x_wr++;
    check_all("wr_legal");
    mem_chk("wr_legal.mem", 10'h012, 16'hBEEF);

    rd("rd_legal", 18'h00012, 16'hBEEF);
    check_all("rd_legal");

    wr_raw(18'h00013, 16'h0F0F, 2, 3, 1'b0);
    x_wr++;
    wr_raw(18'h00013, 16'h1234, 2, 1, 1'b0);
    x_pwe = 1'b1;
    check_all("short");
    mem_chk("short.mem", 10'h013, 16'h0F0F);

    wr_raw(18'h00014, 16'h1111, 2, 3, 1'b0);
    x_wr++;
    addr = 18'h00014; en = 1'b0; oe = 1'b1; we = 1'b1;
    repeat (2) @(negedge clk);
    we = 1'b0; dat = 16'h9999; dat_en = 1'b1;
    repeat (2) @(negedge clk);
    addr = 18'h00015;
    repeat (2) @(negedge clk);
    we = 1'b1;
    @(negedge clk);
    dat_en = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    x_addr = 1'b1;
    check_all("addr_chg");
    mem_chk("addr_chg.mem", 10'h014, 16'h1111);

    wr_raw(18'h00016, 16'h7777, 0, 3, 1'b0);
    x_wr++;
    x_setup = 1'b1;
    check_all("setup");
    mem_chk("setup.mem", 10'h016, 16'h7777);

    addr = 18'h00017; en = 1'b0; oe = 1'b1; we = 1'b1;
    repeat (2) @(negedge clk);
    we = 1'b0; dat = 16'h2222; dat_en = 1'b1;
    repeat (3) @(negedge clk);
    we = 1'b1; addr = 18'h00018;
    @(negedge clk);
    dat_en = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    x_wr++;
    x_hold = 1'b1;
    check_all("hold");
    mem_chk("hold.mem", 10'h017, 16'h2222);

    rd("rd_setup_word", 18'h00016, 16'h7777);

    wr_raw(18'h20400, 16'h5A5A, 2, 3, 1'b0);
    x_wr++;
    check_all("alias_wr");
    mem_chk("alias.mem", 10'h000, 16'h5A5A);
    rd("rd_alias", 18'h00400, 16'h5A5A);

    wr_raw(18'h00030, 16'h3C3C, 2, 3, 1'b0);
    x_wr++;
    wr_raw(18'h00030, 16'h6B6B, 2, 3, 1'b1);
    x_wr++;
    check_all("oe_we");
    mem_chk("oe_we.mem", 10'h030, 16'h6B6B);

    // Reset in the middle of a driven read.
    begin
      exp_t e;
      addr = 18'h00012; en = 1'b0; oe = 1'b0; we = 1'b1;
      e.data = 16'hBEEF;
      e.cyc  = cyc + int'(TAA) + 2;
      sb.push_back(e);
      k = 0;
      while (sb.size() != 0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("rst_mid.pre_drive", 32'(RamData), 32'h0000BEEF);
      rst = 1'b1; oe = 1'b1; en = 1'b1;
      #1;
      chk("rst_mid.bus", 32'(RamData), 32'h0000FFFF);
      x_setup = 0; x_pwe = 0; x_addr = 0; x_hold = 0; x_wr = 0; x_rd = 0;
      check_all("rst_mid");
      @(negedge clk);
      mem_chk("rst_mid.mem", 10'h012, 16'hBEEF);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid.queue", 32'(sb.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
